// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_gen
// Brief    : NoC local-port traffic generator (packet build/inject) and sink.
// Revision : 1.0 - initial release
// ============================================================================
// Flit layout: [18] valid, [17:16] type (01 head, 10 body, 11 tail), [15:0] payload.
module noc_traffic_gen #(
    parameter int          BODY_COUNT  = 2,
    parameter int          NUM_PACKETS = 10,
    parameter int          INJ_GAP     = 0,
    parameter int          MODE        = 0,
    parameter int          MESH_X      = 4,
    parameter int          MESH_Y      = 4,
    parameter int          X_ADDR      = 0,
    parameter int          Y_ADDR      = 0,
    parameter int          DST_X       = 3,
    parameter int          DST_Y       = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         FLIT_SIZE   = 19
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    output logic [FLIT_SIZE-1:0] o_flit,
    output logic                 o_transmit,
    input  logic                 i_send,
    input  logic [FLIT_SIZE-1:0] i_flit,
    input  logic                 i_rec_req,
    output logic                 o_rec_ack,
    output logic [15:0]          o_tx_pkts,
    output logic [15:0]          o_rx_pkts,
    output logic                 o_rx_err,
    output logic                 o_done
);

    localparam logic [1:0]  FT_HEAD    = 2'b01;
    localparam logic [1:0]  FT_BODY    = 2'b10;
    localparam logic [1:0]  FT_TAIL    = 2'b11;
    localparam int          DEPTH      = BODY_COUNT + 2;
    localparam int          PTR_W      = $clog2(DEPTH);
    localparam int          CNT_W      = $clog2(DEPTH + 1);
    localparam logic [3:0]  OWN_X      = 4'(X_ADDR);
    localparam logic [3:0]  OWN_Y      = 4'(Y_ADDR);
    localparam logic [31:0] NUM_PKTS_U = NUM_PACKETS;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_HEAD, S_BODY, S_TAIL, S_REQ, S_SEND, S_DONE
    } tx_state_t;

    tx_state_t              state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [15:0]            seq_q, seq_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             body_idx_q, body_idx_d;
    logic [15:0]            tx_pkts_q, tx_pkts_d;
    logic [15:0]            rx_pkts_q, rx_pkts_d;
    logic                   rx_err_q, rx_err_d;
    logic                   done_q, done_d;
    logic [FLIT_SIZE-1:0]   flit_q, flit_d;
    logic [FLIT_SIZE-1:0]   fifo_q [DEPTH];
    logic [FLIT_SIZE-1:0]   fifo_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   wr_en, rd_en, fifo_full, limit_ok, rx_fire;
    logic [FLIT_SIZE-1:0]   wr_data;
    logic [7:0]             raw_x, raw_y;
    logic [3:0]             rnd_x, rnd_y, dst_x, dst_y;
    logic [7:0]             unused_rx_payload;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full = (cnt_q == CNT_W'(DEPTH));
    assign limit_ok  = (NUM_PACKETS == 0) || ({16'd0, tx_pkts_q} < NUM_PKTS_U);

    // Random destination never targets this node: collisions slide one column.
    always_comb begin
        raw_x = lfsr_q[7:0] % 8'(MESH_X);
        raw_y = lfsr_q[15:8] % 8'(MESH_Y);
        rnd_x = raw_x[3:0];
        rnd_y = raw_y[3:0];
        if (raw_x[3:0] == OWN_X && raw_y[3:0] == OWN_Y) begin
            rnd_x = 4'((5'(raw_x[3:0]) + 5'd1) % 5'(MESH_X));
        end
        if (MODE == 1) begin
            dst_x = 4'(DST_X);
            dst_y = 4'(DST_Y);
        end else if (MODE == 2) begin
            dst_x = OWN_Y;
            dst_y = OWN_X;
        end else begin
            dst_x = rnd_x;
            dst_y = rnd_y;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seq_d      = seq_q;
        gap_d      = gap_q;
        body_idx_d = body_idx_q;
        tx_pkts_d  = tx_pkts_q;
        done_d     = done_q;
        flit_d     = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        rd_en      = 1'b0;
        o_transmit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && limit_ok) begin
                    state_d = (gap_q == 8'd0) ? S_HEAD : S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                wr_en      = 1'b1;
                wr_data    = {1'b1, FT_HEAD, dst_x, dst_y, 8'h00};
                lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                body_idx_d = 8'd0;
                state_d    = S_BODY;
            end
            S_BODY: begin
                wr_en   = 1'b1;
                wr_data = {1'b1, FT_BODY, OWN_X, OWN_Y, body_idx_q};
                if (body_idx_q == 8'(BODY_COUNT - 1)) begin
                    body_idx_d = 8'd0;
                    state_d    = S_TAIL;
                end else begin
                    body_idx_d = body_idx_q + 8'd1;
                end
            end
            S_TAIL: begin
                wr_en   = 1'b1;
                wr_data = {1'b1, FT_TAIL, seq_q};
                state_d = S_REQ;
            end
            S_REQ: begin
                o_transmit = 1'b1;
                if (i_send) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q != '0) begin
                    rd_en  = 1'b1;
                    flit_d = fifo_q[rd_ptr_q];
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tx_pkts_d = (tx_pkts_q == 16'hFFFF) ? tx_pkts_q : tx_pkts_q + 16'd1;
                seq_d     = seq_q + 16'd1;
                gap_d     = 8'(INJ_GAP);
                if (NUM_PACKETS != 0 && {16'd0, tx_pkts_d} >= NUM_PKTS_U) begin
                    done_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en && !fifo_full) begin
            fifo_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            cnt_d            = cnt_d + CNT_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d    = cnt_d - CNT_W'(1);
        end
    end

    // Sink is gated by reset so the ack reads inactive while the block is held.
    assign o_rec_ack         = i_start & reset_n;
    assign rx_fire           = i_flit[FLIT_SIZE-1] & i_rec_req & o_rec_ack;
    assign unused_rx_payload = i_flit[7:0];

    always_comb begin
        rx_pkts_d = rx_pkts_q;
        rx_err_d  = rx_err_q;
        if (rx_fire && i_flit[17:16] == FT_HEAD &&
            (i_flit[15:12] != OWN_X || i_flit[11:8] != OWN_Y)) begin
            rx_err_d = 1'b1;
        end
        if (rx_fire && i_flit[17:16] == FT_TAIL && rx_pkts_q != 16'hFFFF) begin
            rx_pkts_d = rx_pkts_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            seq_q      <= '0;
            gap_q      <= '0;
            body_idx_q <= '0;
            tx_pkts_q  <= '0;
            rx_pkts_q  <= '0;
            rx_err_q   <= 1'b0;
            done_q     <= 1'b0;
            flit_q     <= '0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seq_q      <= seq_d;
            gap_q      <= gap_d;
            body_idx_q <= body_idx_d;
            tx_pkts_q  <= tx_pkts_d;
            rx_pkts_q  <= rx_pkts_d;
            rx_err_q   <= rx_err_d;
            done_q     <= done_d;
            flit_q     <= flit_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(wr_en && fifo_full));

    assign o_flit    = flit_q;
    assign o_tx_pkts = tx_pkts_q;
    assign o_rx_pkts = rx_pkts_q;
    assign o_rx_err  = rx_err_q;
    assign o_done    = done_q;

endmodule
`default_nettype wire

// File: doc/noc_traffic_gen.md
# noc_traffic_gen

Parametrised NoC traffic generator and sink, one per router local port. It builds packets in a local FIFO, requests the router, and streams one flit per cycle on grant. Packet count, packet length, injection gap and destination mode are all parameters. The receive side consumes incoming packets, counts them, and flags misrouted ones.

## Interface
Parameters:
- BODY_COUNT, 2: body flits per packet (1..14).
- NUM_PACKETS, 10: packets to inject; 0 = unbounded.
- INJ_GAP, 0: idle cycles between the end of one packet and the next HEAD (0..255).
- MODE, 0: destination mode. 0 = uniform LFSR, 1 = fixed DST_X/DST_Y, 2 = transpose (dst = (Y_ADDR, X_ADDR)).
- MESH_X, 4 / MESH_Y, 4: mesh dimensions.
- X_ADDR, 0 / Y_ADDR, 0: own router address.
- DST_X, 3 / DST_Y, 3: fixed destination for MODE 1.
- LFSR_SEED, 16'hACE1: nonzero 16-bit seed.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  level enable.
- o_flit  out  FLIT_t  flit to router; '0 when not sending.
- o_transmit  out  1  injection request.
- i_send  in  1  grant from router.
- i_flit  in  FLIT_t  flit from router; valid when flit[FLIT_SIZE-1]=1.
- i_rec_req  in  1  router has a flit for this port.
- o_rec_ack  out  1  sink ready.
- o_tx_pkts  out  16  packets fully sent; saturating.
- o_rx_pkts  out  16  tail flits received; saturating.
- o_rx_err  out  1  sticky: a received head addressed to another node.
- o_done  out  1  NUM_PACKETS sent; held until reset.

## Operation
- TX FSM: IDLE, GAP, HEAD, BODY, TAIL, REQ, SEND, DONE.
- IDLE -> HEAD when i_start=1, tx count < NUM_PACKETS (or NUM_PACKETS=0), and the gap counter is 0.
- IDLE -> GAP when i_start=1, the above limit holds, and the gap counter is nonzero.
- GAP: decrements the gap counter; -> HEAD when it reaches 0.
- HEAD: writes the head flit (valid=1, flit_type=HEAD, dst xaddr/yaddr) -> BODY.
- BODY: writes BODY_COUNT body flits, then -> TAIL. Body payload = {own x, own y, 8-bit body index}.
- TAIL: writes the tail flit with payload = 16-bit packet sequence number (starts at 0, wraps) -> REQ.
- REQ: o_transmit=1; -> SEND when i_send=1.
- SEND: pops one flit per cycle. When the FIFO drains, -> DONE.
- DONE: increments o_tx_pkts and sequence; loads the gap counter with INJ_GAP.
  - -> IDLE.
  - o_done=1 once the count reaches NUM_PACKETS.
- Out FIFO depth = BODY_COUNT+2, so packet build never stalls.
  - An overflow write is dropped. It is an assertion failure in simulation.
- Destination, MODE 0:
  - LFSR (x^16+x^14+x^13+x^11+1) advances once per HEAD.
  - dst_x = lfsr[7:0] mod MESH_X; dst_y = lfsr[15:8] mod MESH_Y.
  - If dst equals own address, dst_x = (dst_x+1) mod MESH_X.
- i_start deasserted mid-packet: the current packet completes through DONE; the next packet is not started. Reassertion resumes, with counts preserved.
- RX sink:
  - o_rec_ack = i_start.
  - Each valid flit with i_rec_req=1 and o_rec_ack=1 is consumed.
  - A HEAD whose x/y differs from own address sets o_rx_err.
  - A TAIL increments o_rx_pkts.
  - Receiving is independent of the TX FSM.

## Timing
- Reset values: o_flit='0, o_transmit=0, o_rec_ack=0, o_tx_pkts=0, o_rx_pkts=0, o_rx_err=0, o_done=0. Internal state: FSM=IDLE, LFSR=LFSR_SEED, sequence=0, gap counter=0.
- Reset mid-packet aborts immediately and flushes the FIFO.
- o_flit is registered. The first flit appears 1 cycle after the SEND entry edge, followed by back-to-back flits.
  - Packet occupies BODY_COUNT+2 consecutive cycles on o_flit.
  - o_flit returns to '0 the cycle after the tail.
- Build latency: i_start rise to o_transmit = BODY_COUNT+3 cycles (IDLE, HEAD, BODY×N, TAIL, REQ) when INJ_GAP=0.
- o_transmit stays high in REQ until i_send is seen. i_send outside REQ is ignored.
- Counters saturate at 16'hFFFF.
- A simultaneous rx tail and tx done update their own counters independently.

## Test plan
- Basic: BODY_COUNT=2, NUM_PACKETS=3, MODE=1, DST=(3,3), i_send tied 1.
  - Expect 3 packets of 4 flits each, tail sequence 0,1,2.
  - Expect o_tx_pkts=3, then o_done=1, and o_transmit never rises again.
- Grant stall: i_send held 0 for 20 cycles in REQ.
  - Expect o_transmit=1 throughout and o_flit='0.
  - After grant, 4 contiguous flits.
- Gap: INJ_GAP=5.
  - Expect ≥5 cycles between a tail on o_flit and the next o_transmit rise.
- Random: MODE=0, X_ADDR=Y_ADDR=0, 200 packets.
  - Expect no head addressed to (0,0).
  - Every dst within 0..3.
  - Sequence matches the reference LFSR model.
- Sink: drive 5 packets addressed to own, then 1 addressed to (2,1).
  - Expect o_rx_pkts=6 and o_rx_err=1, sticky.
- Reset mid-SEND after 2 flits.
  - Expect all outputs at reset values next cycle.
  - Expect a clean first packet with sequence 0 after release.
